// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C FSM state encodings and bus constants.
// Used by i2c_target (and i2c_master) via import i2c_pkg::*.
package i2c_pkg;

  typedef logic [2:0] i2c_state_t;

  localparam i2c_state_t ST_IDLE     = 3'd0;
  localparam i2c_state_t ST_ADDR     = 3'd1;
  localparam i2c_state_t ST_ADDR_ACK = 3'd2;
  localparam i2c_state_t ST_WR_DATA  = 3'd3;
  localparam i2c_state_t ST_WR_ACK   = 3'd4;
  localparam i2c_state_t ST_RD_DATA  = 3'd5;
  localparam i2c_state_t ST_RD_ACK   = 3'd6;
  localparam i2c_state_t ST_IGNORE   = 3'd7;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-flop synchronisers + history flop on SCL/SDA, with
// registered SCL edge and START/STOP pulses (3 clk latency).
// Ports: clk, rst_n, scl_in, sda_in -> scl_rise, scl_fall,
//        start_det, stop_det, sda_s (SDA aligned with the pulses).
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] meta, [1] synced, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       rise_q;
  logic       fall_q;
  logic       start_q;
  logic       stop_q;

  // Sync chain resets to the idle bus level so reset itself
  // cannot fake an edge while the bus is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      scl_q   <= {scl_q[1:0], scl_in};
      sda_q   <= {sda_q[1:0], sda_in};
      rise_q  <= scl_q[1] & ~scl_q[2];
      fall_q  <= ~scl_q[1] & scl_q[2];
      start_q <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_q  <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end

  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_s     = sda_q[2];

endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit addressed I2C target, open-drain SDA (drive-low only).
// Ports: bus (scl_in, sda_in, sda_drive_low), rx stream (rx_data,
// rx_valid, rx_ready), tx stream (tx_data, tx_valid, tx_pop), status
// (tx_underrun, busy, addressed).
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h44,
  parameter int unsigned SDA_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_pop,
  output logic       tx_underrun,
  output logic       busy,
  output logic       addressed
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  i2c_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [3:0] hold_q, hold_d;
  logic rw_q, rw_d;
  logic ld_q, ld_d;
  logic tgt_q, tgt_d;
  logic drv_q, drv_d;
  logic rx_valid_q, rx_valid_d;
  logic pop_q, pop_d;
  logic unr_q, unr_d;
  logic busy_q, busy_d;
  logic addr_q, addr_d;
  logic load_now;

  // tgt_* is the wanted SDA drive; it reaches the pin only
  // SDA_HOLD clk after an SCL fall, so it never moves while SCL=1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    ld_d       = ld_q;
    tgt_d      = tgt_q;
    rx_valid_d = 1'b0;
    pop_d      = 1'b0;
    unr_d      = unr_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    load_now   = 1'b0;
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      busy_d  = 1'b1;
      addr_d  = 1'b0;
      unr_d   = 1'b0;
      tgt_d   = 1'b0;
      ld_d    = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      busy_d  = 1'b0;
      addr_d  = 1'b0;
      tgt_d   = 1'b0;
      ld_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (shift_d[7:1] == DEV_ADDR) begin
              rw_d    = sda_s;
              addr_d  = 1'b1;
              tgt_d   = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        // first fall starts the ACK bit, second fall ends it
        ST_ADDR_ACK: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            cnt_d = 3'd0;
            if (rw_q == I2C_RW_READ) begin
              load_now = 1'b1;
              state_d  = ST_RD_DATA;
            end else begin
              tgt_d   = 1'b0;
              state_d = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d      = 3'd0;
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            if (rx_ready) begin
              tgt_d   = 1'b1;
              state_d = ST_WR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            cnt_d   = 3'd0;
            tgt_d   = 1'b0;
            state_d = ST_WR_DATA;
          end
        end
        // ld_q: byte after a master ACK is loaded at the next fall
        ST_RD_DATA: if (scl_fall) begin
          if (ld_q) begin
            ld_d     = 1'b0;
            load_now = 1'b1;
          end else if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            tgt_d   = 1'b0;
            state_d = ST_RD_ACK;
          end else begin
            shift_d = {shift_q[6:0], 1'b1};
            tgt_d   = ~shift_q[6];
            cnt_d   = cnt_q + 3'd1;
          end
        end
        ST_RD_ACK: if (scl_rise) begin
          cnt_d = 3'd0;
          if (sda_s == I2C_ACK) begin
            ld_d    = 1'b1;
            state_d = ST_RD_DATA;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_IGNORE: tgt_d = 1'b0;
        default: state_d = state_q;
      endcase
      if (load_now) begin
        if (tx_valid) begin
          shift_d = tx_data;
          pop_d   = 1'b1;
        end else begin
          shift_d = 8'hFF;
          unr_d   = 1'b1;
        end
        tgt_d = ~shift_d[7];
      end
    end
  end

  always_comb begin
    drv_d  = drv_q;
    hold_d = hold_q;
    if (start_det || stop_det) begin
      drv_d  = 1'b0;
      hold_d = 4'd0;
    end else if (scl_fall) begin
      hold_d = 4'(SDA_HOLD);
    end else if (hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
      if (hold_q == 4'd1) drv_d = tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      hold_q     <= 4'd0;
      rw_q       <= 1'b0;
      ld_q       <= 1'b0;
      tgt_q      <= 1'b0;
      drv_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      pop_q      <= 1'b0;
      unr_q      <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      hold_q     <= hold_d;
      rw_q       <= rw_d;
      ld_q       <= ld_d;
      tgt_q      <= tgt_d;
      drv_q      <= drv_d;
      rx_valid_q <= rx_valid_d;
      pop_q      <= pop_d;
      unr_q      <= unr_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
    end
  end

  // gated by rst_n so asserting reset frees the bus at once
  assign sda_drive_low = drv_q & rst_n;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign tx_pop        = pop_q;
  assign tx_underrun   = unr_q;
  assign busy          = busy_q;
  assign addressed     = addr_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-level bench for i2c_target.
// Bit-banged master, small tx FIFO model, rx log, pop counter.
module tb_i2c_target;

  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_drive_low, rx_valid, tx_pop;
  logic       tx_underrun, busy, addressed, tx_valid;
  logic [7:0] rx_data, tx_data;

  logic [7:0] fifo [0:7];
  logic [7:0] rx_log [0:15];
  int wp = 0, rp = 0;
  int rx_n = 0, pops = 0, viol = 0;
  int total = 0, bad = 0;
  logic prev_drv = 1'b0;

  assign scl_in   = scl_m;
  assign sda_in   = sda_m & ~sda_drive_low;
  assign tx_valid = (rp < wp);
  assign tx_data  = fifo[rp[2:0]];

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h44), .SDA_HOLD(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sda_drive_low(sda_drive_low),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_pop       (tx_pop),
    .tx_underrun  (tx_underrun),
    .busy         (busy),
    .addressed    (addressed)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_n[3:0]] = rx_data;
      rx_n++;
    end
    if (tx_pop) begin
      pops++;
      rp++;
    end
    if (rst_n && scl_in && (sda_drive_low != prev_drv)) viol++;
    prev_drv = sda_drive_low;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bstart;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bstop;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic bit_io(input logic b, output logic r);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    r = sda_in;   tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(mack, r);
  endtask

  initial begin
    tick(60000);
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] d;

    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_drv", sda_drive_low, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 8'h00);
    chk("rst_pop", tx_pop, 0);
    chk("rst_unr", tx_underrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addressed, 0);

    // write 0x44+W, A5, 3C
    bstart;
    chk("w_busy", busy, 1);
    wr_byte(8'h88, a);
    chk("w_aack", a, 0);
    chk("w_addr", addressed, 1);
    wr_byte(8'hA5, a);
    chk("w_ack1", a, 0);
    wr_byte(8'h3C, a);
    chk("w_ack2", a, 0);
    bstop;
    chk("w_rxn", rx_n, 2);
    chk("w_rx0", rx_log[0], 8'hA5);
    chk("w_rx1", rx_log[1], 8'h3C);
    chk("w_busy0", busy, 0);
    chk("w_addr0", addressed, 0);

    // read 0x44+R: 66, 1D, C2
    fifo[0] = 8'h66; fifo[1] = 8'h1D; fifo[2] = 8'hC2; wp = 3;
    bstart;
    wr_byte(8'h89, a);
    chk("r_aack", a, 0);
    rd_byte(1'b0, d);
    chk("r_b0", d, 8'h66);
    rd_byte(1'b0, d);
    chk("r_b1", d, 8'h1D);
    rd_byte(1'b1, d);
    chk("r_b2", d, 8'hC2);
    bstop;
    chk("r_pops", pops, 3);
    chk("r_unr", tx_underrun, 0);

    // wrong address 0x45+W
    bstart;
    wr_byte(8'h8A, a);
    chk("n_aack", a, 1);
    chk("n_addr", addressed, 0);
    wr_byte(8'h88, a);
    chk("n_ign", a, 1);
    bstop;
    chk("n_rxn", rx_n, 2);

    // write 01, repeated START, read with empty FIFO
    bstart;
    wr_byte(8'h88, a);
    chk("s_aack", a, 0);
    wr_byte(8'h01, a);
    chk("s_ack", a, 0);
    bstart;
    chk("s_addr0", addressed, 0);
    wr_byte(8'h89, a);
    chk("s_rack", a, 0);
    chk("s_addr1", addressed, 1);
    rd_byte(1'b1, d);
    chk("s_ff", d, 8'hFF);
    chk("s_unr", tx_underrun, 1);
    bstop;
    chk("s_unr_st", tx_underrun, 1);
    chk("s_rxn", rx_n, 3);
    chk("s_rx", rx_log[2], 8'h01);
    chk("s_pops", pops, 3);

    // rx_ready=0 -> NACK, then ignored
    bstart;
    chk("k_unr0", tx_underrun, 0);
    wr_byte(8'h88, a);
    chk("k_aack", a, 0);
    rx_ready = 1'b0;
    wr_byte(8'h7E, a);
    chk("k_nack", a, 1);
    chk("k_rx", rx_log[3], 8'h7E);
    rx_ready = 1'b1;
    wr_byte(8'h55, a);
    chk("k_ign", a, 1);
    chk("k_rxn", rx_n, 4);
    bstop;

    // reset while driving a read bit low
    fifo[3] = 8'h00; wp = 4;
    bstart;
    wr_byte(8'h89, a);
    chk("x_aack", a, 0);
    chk("x_drv1", sda_drive_low, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("x_drv0", sda_drive_low, 0);
    chk("x_busy", busy, 0);
    chk("x_addr", addressed, 0);
    chk("x_rxd", rx_data, 8'h00);
    chk("x_pop", tx_pop, 0);
    wr_byte(8'h88, a);
    chk("x_idle", a, 1);
    chk("x_busy2", busy, 0);
    bstop;
    bstart;
    wr_byte(8'h88, a);
    chk("x_rec", a, 0);
    bstop;
    chk("x_pops", pops, 4);
    chk("sda_hold", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
